// File: rtl/spi_sts_latch.sv
// Sticky SPI fault collector: latches synchronized fault levels, records the first unmasked fault
// with a run timestamp and drives a level irq. Optional event counter: SPI_STS_EVT_CNT_EN.
module spi_sts_latch #(
    parameter int unsigned N_GRP = 10,
    parameter int unsigned TS_W  = 32,
    parameter int unsigned EVT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_running,
    input  logic [8*N_GRP-1:0]   sts_flags,
    input  logic [N_GRP-1:0]     grp_mask,
    input  logic                 clr_all,
    input  logic                 clr_grp,
    input  logic [3:0]           clr_grp_idx,
    output logic [8*N_GRP-1:0]   sticky,
    output logic                 stop_evt,
    output logic [TS_W-1:0]      ts_cnt,
    output logic                 ff_valid,
    output logic [3:0]           ff_grp,
    output logic [2:0]           ff_ch,
    output logic [TS_W-1:0]      ff_time,
    output logic                 irq
`ifdef SPI_STS_EVT_CNT_EN
    ,
    output logic [EVT_W-1:0]     evt_cnt
`endif
);

    localparam int unsigned NB = 8 * N_GRP;

    logic [NB-1:0]   sticky_q, sticky_d;
    logic [NB-1:0]   mask_exp, clr_bits, new_bits;
    logic            running_q;
    logic            stop_evt_q, stop_evt_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            ff_valid_q, ff_valid_d;
    logic [3:0]      ff_grp_q, ff_grp_d;
    logic [2:0]      ff_ch_q, ff_ch_d;
    logic [TS_W-1:0] ff_time_q, ff_time_d;
    logic            irq_q, irq_d;
    logic [3:0]      hit_grp;
    logic [2:0]      hit_ch;

    always_comb begin
        mask_exp = '0;
        clr_bits = '0;
        for (int g = 0; g < N_GRP; g++) begin
            mask_exp[8*g +: 8] = {8{grp_mask[g]}};
            if (clr_grp && clr_grp_idx == 4'(g)) begin
                clr_bits[8*g +: 8] = '1;
            end
        end
        // Set beats clear: input bits are OR-ed in after any clear.
        if (clr_all) begin
            sticky_d = sts_flags;
        end else begin
            sticky_d = (sticky_q & ~clr_bits) | sts_flags;
        end
    end

    // Scan high to low so the lowest group, then lowest channel, is the last written.
    always_comb begin
        new_bits = sts_flags & ~sticky_q & ~mask_exp;
        hit_grp  = '0;
        hit_ch   = '0;
        for (int g = N_GRP - 1; g >= 0; g--) begin
            for (int c = 7; c >= 0; c--) begin
                if (new_bits[8*g + c]) begin
                    hit_grp = 4'(g);
                    hit_ch  = 3'(c);
                end
            end
        end
    end

    always_comb begin
        ff_valid_d = ff_valid_q;
        ff_grp_d   = ff_grp_q;
        ff_ch_d    = ff_ch_q;
        ff_time_d  = ff_time_q;
        stop_evt_d = stop_evt_q;
        ts_d       = ts_q;

        if (clr_all) begin
            ff_valid_d = 1'b0;
            ff_grp_d   = '0;
            ff_ch_d    = '0;
            ff_time_d  = '0;
            stop_evt_d = 1'b0;
        end else begin
            if (!ff_valid_q && |new_bits) begin
                ff_valid_d = 1'b1;
                ff_grp_d   = hit_grp;
                ff_ch_d    = hit_ch;
                ff_time_d  = ts_q;
            end
            if (!spi_running && running_q) begin
                stop_evt_d = 1'b1;
            end
        end

        if (spi_running && !running_q) begin
            ts_d = '0;
        end else if (spi_running && ts_q != '1) begin
            ts_d = ts_q + TS_W'(1);
        end

        irq_d = |(sticky_q & ~mask_exp) | stop_evt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q   <= '0;
            running_q  <= 1'b0;
            stop_evt_q <= 1'b0;
            ts_q       <= '0;
            ff_valid_q <= 1'b0;
            ff_grp_q   <= '0;
            ff_ch_q    <= '0;
            ff_time_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            sticky_q   <= sticky_d;
            running_q  <= spi_running;
            stop_evt_q <= stop_evt_d;
            ts_q       <= ts_d;
            ff_valid_q <= ff_valid_d;
            ff_grp_q   <= ff_grp_d;
            ff_ch_q    <= ff_ch_d;
            ff_time_q  <= ff_time_d;
            irq_q      <= irq_d;
        end
    end

`ifdef SPI_STS_EVT_CNT_EN
    localparam int unsigned PcW = $clog2(NB + 1);

    logic [PcW-1:0]   rise_cnt;
    logic [EVT_W:0]   evt_sum;
    logic [EVT_W-1:0] evt_q, evt_d;

    always_comb begin
        rise_cnt = '0;
        for (int i = 0; i < NB; i++) begin
            if (sticky_d[i] && !sticky_q[i]) begin
                rise_cnt = rise_cnt + PcW'(1);
            end
        end
        evt_sum = {1'b0, evt_q} + (EVT_W + 1)'(rise_cnt);
        if (clr_all) begin
            evt_d = '0;
        end else if (evt_sum[EVT_W]) begin
            evt_d = '1;
        end else begin
            evt_d = evt_sum[EVT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign evt_cnt = evt_q;
`else
    // Event counter not built.
`endif

    assign sticky   = sticky_q;
    assign stop_evt = stop_evt_q;
    assign ts_cnt   = ts_q;
    assign ff_valid = ff_valid_q;
    assign ff_grp   = ff_grp_q;
    assign ff_ch    = ff_ch_q;
    assign ff_time  = ff_time_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_spi_sts_latch.sv
// Directed bench for spi_sts_latch; also covers evt_cnt when SPI_STS_EVT_CNT_EN is defined.
module tb_spi_sts_latch;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_running;
    logic [79:0] sts_flags;
    logic [9:0]  grp_mask;
    logic        clr_all;
    logic        clr_grp;
    logic [3:0]  clr_grp_idx;
    logic [79:0] sticky;
    logic        stop_evt;
    logic [31:0] ts_cnt;
    logic        ff_valid;
    logic [3:0]  ff_grp;
    logic [2:0]  ff_ch;
    logic [31:0] ff_time;
    logic        irq;
`ifdef SPI_STS_EVT_CNT_EN
    logic [15:0] evt_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spi_sts_latch dut (
        .clk         (clk),
        .rst         (rst),
        .spi_running (spi_running),
        .sts_flags   (sts_flags),
        .grp_mask    (grp_mask),
        .clr_all     (clr_all),
        .clr_grp     (clr_grp),
        .clr_grp_idx (clr_grp_idx),
        .sticky      (sticky),
        .stop_evt    (stop_evt),
        .ts_cnt      (ts_cnt),
        .ff_valid    (ff_valid),
        .ff_grp      (ff_grp),
        .ff_ch       (ff_ch),
        .ff_time     (ff_time),
        .irq         (irq)
`ifdef SPI_STS_EVT_CNT_EN
        ,
        .evt_cnt     (evt_cnt)
`endif
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] req);
        tests++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    function automatic logic [79:0] bit_of(input int i);
        logic [79:0] one;
        one = 80'd1;
        return one << i;
    endfunction

    initial begin
        rst = 1'b1; spi_running = 1'b0; sts_flags = '0; grp_mask = '0;
        clr_all = 1'b0; clr_grp = 1'b0; clr_grp_idx = '0;
        step(3);
        rst = 1'b0;
        step(10);
        chk("rst_sticky", sticky, '0);
        chk("rst_stop", 80'(stop_evt), 80'd0);
        chk("rst_ts", 80'(ts_cnt), 80'd0);
        chk("rst_ffv", 80'(ff_valid), 80'd0);
        chk("rst_fft", 80'(ff_time), 80'd0);
        chk("rst_irq", 80'(irq), 80'd0);

        // Rising edge loads 0, then +1 per edge: 100 edges -> 99.
        spi_running = 1'b1;
        step(100);
        chk("ts_run", 80'(ts_cnt), 80'd99);

        sts_flags = bit_of(51);
        step(1);
        sts_flags = '0;
        chk("s51_sticky", sticky, bit_of(51));
        chk("s51_ffv", 80'(ff_valid), 80'd1);
        chk("s51_grp", 80'(ff_grp), 80'd6);
        chk("s51_ch", 80'(ff_ch), 80'd3);
        chk("s51_time", 80'(ff_time), 80'd99);
        chk("s51_irq0", 80'(irq), 80'd0);
        step(1);
        chk("s51_irq1", 80'(irq), 80'd1);
        chk("s51_held", sticky, bit_of(51));
`ifdef SPI_STS_EVT_CNT_EN
        chk("evt_1", 80'(evt_cnt), 80'd1);
`endif

        clr_all = 1'b1;
        step(1);
        clr_all = 1'b0;
        chk("ca_sticky", sticky, '0);
        chk("ca_ffv", 80'(ff_valid), 80'd0);
        chk("ca_ts", 80'(ts_cnt), 80'd102);
`ifdef SPI_STS_EVT_CNT_EN
        chk("evt_clr", 80'(evt_cnt), 80'd0);
`endif
        step(1);
        chk("ca_irq", 80'(irq), 80'd0);

        sts_flags = bit_of(9) | bit_of(70);
        step(1);
        sts_flags = bit_of(2);
        chk("p2_grp", 80'(ff_grp), 80'd1);
        chk("p2_ch", 80'(ff_ch), 80'd1);
        chk("p2_time", 80'(ff_time), 80'd103);
        step(1);
        sts_flags = '0;
        chk("p3_grp", 80'(ff_grp), 80'd1);
        chk("p3_ch", 80'(ff_ch), 80'd1);
        chk("p3_time", 80'(ff_time), 80'd103);
        chk("p3_sticky", sticky, bit_of(2) | bit_of(9) | bit_of(70));
`ifdef SPI_STS_EVT_CNT_EN
        chk("evt_3", 80'(evt_cnt), 80'd3);
`endif

        clr_all = 1'b1;
        step(1);
        clr_all = 1'b0;
        step(1);

        // Masked group sets sticky but neither captures nor interrupts.
        grp_mask = 10'h004;
        sts_flags = bit_of(16);
        step(1);
        sts_flags = '0;
        chk("m_sticky", sticky, bit_of(16));
        chk("m_ffv", 80'(ff_valid), 80'd0);
        step(1);
        chk("m_irq", 80'(irq), 80'd0);
        grp_mask = '0;
        step(1);
        chk("unm_irq", 80'(irq), 80'd1);
        chk("unm_ts", 80'(ts_cnt), 80'd110);

        clr_all = 1'b1;
        step(1);
        clr_all = 1'b0;
        sts_flags = bit_of(40) | bit_of(3);
        step(1);
        sts_flags = bit_of(40);
        chk("g_ffgrp", 80'(ff_grp), 80'd0);
        chk("g_ffch", 80'(ff_ch), 80'd3);
        chk("g_fftime", 80'(ff_time), 80'd111);
        clr_grp = 1'b1; clr_grp_idx = 4'd5;
        step(1);
        chk("g_setwins", sticky, bit_of(40) | bit_of(3));
        sts_flags = '0;
        step(1);
        chk("g_clr5", sticky, bit_of(3));
        clr_grp_idx = 4'd12;
        step(1);
        clr_grp = 1'b0;
        chk("g_idx12", sticky, bit_of(3));
        chk("g_ts", 80'(ts_cnt), 80'd115);

        clr_all = 1'b1;
        step(1);
        clr_all = 1'b0;
        step(1);
        chk("f_irq_pre", 80'(irq), 80'd0);
        spi_running = 1'b0;
        step(1);
        chk("f_stop", 80'(stop_evt), 80'd1);
        chk("f_ts_hold", 80'(ts_cnt), 80'd117);
        step(1);
        chk("f_irq", 80'(irq), 80'd1);
        chk("f_ts_hold2", 80'(ts_cnt), 80'd117);
        clr_all = 1'b1;
        step(1);
        clr_all = 1'b0;
        chk("f_stop_clr", 80'(stop_evt), 80'd0);
        step(1);
        chk("f_irq_clr", 80'(irq), 80'd0);
        chk("f_sticky", sticky, '0);

        // clr_all with a concurrent fault: sticky set, no capture.
        sts_flags = bit_of(5);
        clr_all = 1'b1;
        step(1);
        clr_all = 1'b0;
        step(1);
        sts_flags = '0;
        chk("cf_sticky", sticky, bit_of(5));
        chk("cf_ffv", 80'(ff_valid), 80'd0);

`ifdef SPI_STS_EVT_CNT_EN
        clr_all = 1'b1;
        step(1);
        clr_all = 1'b0;
        sts_flags = bit_of(0) | bit_of(33) | bit_of(79);
        step(1);
        sts_flags = '0;
        chk("evt_3b", 80'(evt_cnt), 80'd3);
        clr_all = 1'b1;
        step(1);
        clr_all = 1'b0;
        chk("evt_clr2", 80'(evt_cnt), 80'd0);
`endif

        spi_running = 1'b1;
        step(1);
        chk("rise_ts0", 80'(ts_cnt), 80'd0);
        step(1);
        chk("rise_ts1", 80'(ts_cnt), 80'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
